// File: rtl/csr_req_sched.sv
// Round-robin arbiter for the per-core CSR execute port: probes the candidate's warp
// for drain, then forwards its sop..eop packets uninterrupted.
module csr_req_sched #(
  parameter int NUM_REQS      = 4,
  parameter int NW_WIDTH      = 4,
  parameter int DATAW         = 64,
  parameter int PROBE_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          req_valid,
  input  logic [NUM_REQS*NW_WIDTH-1:0] req_wid,
  input  logic [NUM_REQS-1:0]          req_sop,
  input  logic [NUM_REQS-1:0]          req_eop,
  input  logic [NUM_REQS*DATAW-1:0]    req_data,
  output logic [NUM_REQS-1:0]          req_ready,
  output logic [NW_WIDTH-1:0]          alm_empty_wid,
  input  logic                         alm_empty,
  output logic                         out_valid,
  output logic [NW_WIDTH-1:0]          out_wid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [DATAW-1:0]             out_data,
  output logic [$clog2(NUM_REQS)-1:0]  out_idx,
  input  logic                         out_ready
);

  localparam int IDXW = $clog2(NUM_REQS);
  localparam int CNTW = $clog2(PROBE_TIMEOUT);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQS - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(PROBE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_BURST} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]        cand_q, cand_d;
  logic [CNTW-1:0]        probe_cnt_q, probe_cnt_d;

  logic [NUM_REQS-1:0][NW_WIDTH-1:0] wid_arr;
  logic [NUM_REQS-1:0][DATAW-1:0]    data_arr;
  logic [IDXW-1:0]        pick_idx;
  logic [IDXW-1:0]        rr_next;
  logic [NUM_REQS-1:0]    others_valid;

  assign wid_arr  = req_wid;
  assign data_arr = req_data;

  assign out_idx       = cand_q;
  assign alm_empty_wid = wid_arr[cand_q];
  assign out_wid       = wid_arr[cand_q];
  assign out_data      = data_arr[cand_q];
  assign out_sop       = req_sop[cand_q];
  assign out_eop       = req_eop[cand_q];
  assign rr_next       = (cand_q == LAST_IDX) ? '0 : cand_q + 1'b1;

  // Scan downward so the nearest valid index at or after rr_ptr is the last to win.
  always_comb begin : pick_first
    logic [IDXW-1:0] j;
    j        = '0;
    pick_idx = rr_ptr_q;
    for (int unsigned k = NUM_REQS; k > 0; k--) begin
      j = IDXW'((32'(rr_ptr_q) + k - 1) % NUM_REQS);
      if (req_valid[j]) pick_idx = j;
    end
  end

  always_comb begin
    others_valid         = req_valid;
    others_valid[cand_q] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cand_d      = cand_q;
    probe_cnt_d = probe_cnt_q;
    out_valid   = 1'b0;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          cand_d      = pick_idx;
          probe_cnt_d = '0;
          state_d     = S_PROBE;
        end
      end
      S_PROBE: begin
        if (!req_valid[cand_q]) begin
          state_d = S_IDLE;
        end else if (alm_empty) begin
          state_d = S_BURST;
        end else if (probe_cnt_q == CNT_MAX && |others_valid) begin
          rr_ptr_d = rr_next;
          state_d  = S_IDLE;
        end else if (probe_cnt_q != CNT_MAX) begin
          probe_cnt_d = probe_cnt_q + 1'b1;
        end
      end
      S_BURST: begin
        out_valid         = req_valid[cand_q];
        req_ready[cand_q] = out_ready;
        if (req_valid[cand_q] && out_ready && req_eop[cand_q]) begin
          rr_ptr_d = rr_next;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cand_q      <= '0;
      probe_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cand_q      <= cand_d;
      probe_cnt_q <= probe_cnt_d;
    end
  end

  // A requester under probe must keep its instruction presented.
  a_probe_valid_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_PROBE) |-> req_valid[cand_q]);

endmodule

// File: tb/tb_csr_req_sched.sv
// Directed bench for csr_req_sched: table of per-cycle vectors plus hand sequences
// for probe timeout, alm_empty/timeout collision and reset mid-burst.
module tb_csr_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_sop, req_eop, req_ready;
  logic [15:0] req_wid;
  logic [255:0] req_data;
  logic [3:0]  alm_empty_wid;
  logic        alm_empty;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [3:0]  out_wid;
  logic [63:0] out_data;
  logic [1:0]  out_idx;

  logic [7:0]  pkt;
  logic        busy_mode, alm_tb;
  logic [3:0]  busy_wid;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  csr_req_sched #(.NUM_REQS(4), .NW_WIDTH(4), .DATAW(64), .PROBE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wid(req_wid),
    .req_sop(req_sop), .req_eop(req_eop), .req_data(req_data), .req_ready(req_ready),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty), .out_valid(out_valid),
    .out_wid(out_wid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_idx(out_idx), .out_ready(out_ready)
  );

  function automatic logic [3:0] wid_of(input int i);
    case (i)
      0: return 4'd3;
      1: return 4'd9;
      2: return 4'd5;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic [63:0] mk_data(input int i, input logic [7:0] p);
    return {8'(i), 48'h1234_5678_9ABC, p};
  endfunction

  // Busy responder: warp busy_wid never reports empty.
  assign alm_empty = busy_mode ? (alm_empty_wid != busy_wid) : alm_tb;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_wid[i*4 +: 4]    = wid_of(i);
      req_data[i*64 +: 64] = mk_data(i, pkt);
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] vld, sop, eop;
    logic       alm, ordy;
    logic [7:0] p;
    logic       eov;
    logic [3:0] erdy;
    logic [1:0] eidx;
  } vec_t;

  function automatic vec_t V(input logic r, input logic [3:0] v, input logic [3:0] s,
                             input logic [3:0] e, input logic a, input logic o,
                             input logic [7:0] p, input logic eov, input logic [3:0] erdy,
                             input logic [1:0] eidx);
    vec_t t;
    t.rst = r; t.vld = v; t.sop = s; t.eop = e; t.alm = a; t.ordy = o;
    t.p = p; t.eov = eov; t.erdy = erdy; t.eidx = eidx;
    return t;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [3:0] v,
                     input logic [3:0] s, input logic [3:0] e, input logic a,
                     input logic o, input logic [7:0] p, input logic eov,
                     input logic [3:0] erdy, input logic [1:0] eidx);
    @(negedge clk);
    reset = r; req_valid = v; req_sop = s; req_eop = e; alm_tb = a;
    out_ready = o; pkt = p;
    #2;
    cmp(tag, "out_valid", 64'(out_valid), 64'(eov));
    cmp(tag, "req_ready", 64'(req_ready), 64'(erdy));
    cmp(tag, "out_idx", 64'(out_idx), 64'(eidx));
    cmp(tag, "alm_empty_wid", 64'(alm_empty_wid), 64'(wid_of(int'(eidx))));
    if (eov) begin
      cmp(tag, "out_wid", 64'(out_wid), 64'(wid_of(int'(eidx))));
      cmp(tag, "out_data", out_data, mk_data(int'(eidx), p));
      cmp(tag, "out_sop", 64'(out_sop), 64'(s[eidx]));
      cmp(tag, "out_eop", 64'(out_eop), 64'(e[eidx]));
    end
  endtask

  vec_t tbl[31];

  initial begin
    reset = 1'b1; req_valid = '0; req_sop = '0; req_eop = '0; alm_tb = 1'b0;
    out_ready = 1'b0; pkt = '0; busy_mode = 1'b0; busy_wid = '0;
    repeat (2) @(posedge clk);

    // single request from requester 2
    tbl[0]  = V(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 8'h00, 0, 4'b0000, 0);
    tbl[1]  = V(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 8'h00, 0, 4'b0000, 2);
    tbl[2]  = V(0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 8'h00, 1, 4'b0100, 2);
    tbl[3]  = V(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 2);
    tbl[4]  = V(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 2);
    tbl[5]  = V(1, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 0);
    // all four valid: grants 0,1,2,3 every 3 cycles
    tbl[6]  = V(0, 4'b1111, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 0);
    tbl[7]  = V(0, 4'b1111, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 0);
    tbl[8]  = V(0, 4'b1111, 4'b1111, 4'b1111, 1, 1, 8'h00, 1, 4'b0001, 0);
    tbl[9]  = V(0, 4'b1110, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 0);
    tbl[10] = V(0, 4'b1110, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 1);
    tbl[11] = V(0, 4'b1110, 4'b1111, 4'b1111, 1, 1, 8'h00, 1, 4'b0010, 1);
    tbl[12] = V(0, 4'b1100, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 1);
    tbl[13] = V(0, 4'b1100, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 2);
    tbl[14] = V(0, 4'b1100, 4'b1111, 4'b1111, 1, 1, 8'h00, 1, 4'b0100, 2);
    tbl[15] = V(0, 4'b1000, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 2);
    tbl[16] = V(0, 4'b1000, 4'b1111, 4'b1111, 1, 1, 8'h00, 0, 4'b0000, 3);
    tbl[17] = V(0, 4'b1000, 4'b1111, 4'b1111, 1, 1, 8'h00, 1, 4'b1000, 3);
    tbl[18] = V(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 3);
    // 4-packet burst from requester 1 with backpressure while requester 0 waits
    tbl[19] = V(0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 8'h01, 0, 4'b0000, 3);
    tbl[20] = V(0, 4'b0011, 4'b0011, 4'b0001, 1, 1, 8'h01, 0, 4'b0000, 1);
    tbl[21] = V(0, 4'b0011, 4'b0011, 4'b0001, 1, 0, 8'h01, 1, 4'b0000, 1);
    tbl[22] = V(0, 4'b0011, 4'b0011, 4'b0001, 1, 1, 8'h01, 1, 4'b0010, 1);
    tbl[23] = V(0, 4'b0011, 4'b0001, 4'b0001, 1, 1, 8'h02, 1, 4'b0010, 1);
    tbl[24] = V(0, 4'b0011, 4'b0001, 4'b0001, 1, 0, 8'h03, 1, 4'b0000, 1);
    tbl[25] = V(0, 4'b0011, 4'b0001, 4'b0001, 1, 1, 8'h03, 1, 4'b0010, 1);
    tbl[26] = V(0, 4'b0011, 4'b0001, 4'b0011, 1, 1, 8'h04, 1, 4'b0010, 1);
    tbl[27] = V(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h05, 0, 4'b0000, 1);
    tbl[28] = V(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h05, 0, 4'b0000, 0);
    tbl[29] = V(0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h05, 1, 4'b0001, 0);
    tbl[30] = V(0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 0);

    for (int i = 0; i < 31; i++)
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].vld, tbl[i].sop, tbl[i].eop,
          tbl[i].alm, tbl[i].ordy, tbl[i].p, tbl[i].eov, tbl[i].erdy, tbl[i].eidx);

    // timeout rotation: warp of requester 0 stays busy, requester 3 waiting
    cyc("to_rst0", 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'h00, 0, 4'b0000, 0);
    cyc("to_rst1", 1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 8'h00, 0, 4'b0000, 0);
    busy_mode = 1'b1; busy_wid = 4'd3;
    cyc("to_idle", 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h20, 0, 4'b0000, 0);
    for (int k = 0; k < 16; k++)
      cyc($sformatf("to_probe%0d", k), 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h20, 0, 4'b0000, 0);
    cyc("to_rot_idle", 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h20, 0, 4'b0000, 0);
    cyc("to_probe3", 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h20, 0, 4'b0000, 3);
    cyc("to_grant3", 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h20, 1, 4'b1000, 3);
    // no other requester: probe holds past the timeout
    cyc("hold_idle", 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 8'h21, 0, 4'b0000, 3);
    for (int k = 0; k < 20; k++)
      cyc($sformatf("hold_probe%0d", k), 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 8'h21, 0, 4'b0000, 0);
    busy_mode = 1'b0;
    cyc("hold_empty", 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h21, 0, 4'b0000, 0);
    cyc("hold_grant0", 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h21, 1, 4'b0001, 0);

    // alm_empty arriving on the timeout cycle wins over rotation
    busy_mode = 1'b1; busy_wid = 4'd12;
    cyc("col_idle", 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h30, 0, 4'b0000, 0);
    for (int k = 0; k < 15; k++)
      cyc($sformatf("col_probe%0d", k), 0, 4'b1001, 4'b1001, 4'b1001, 0, 1, 8'h30, 0, 4'b0000, 3);
    busy_mode = 1'b0;
    cyc("col_last", 0, 4'b1001, 4'b1001, 4'b1001, 1, 1, 8'h30, 0, 4'b0000, 3);
    cyc("col_burst", 0, 4'b1001, 4'b1001, 4'b1001, 1, 1, 8'h30, 1, 4'b1000, 3);

    // move rr_ptr off zero, then reset in the middle of a burst
    cyc("pre_idle", 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h40, 0, 4'b0000, 3);
    cyc("pre_probe", 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h40, 0, 4'b0000, 0);
    cyc("pre_grant", 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 8'h40, 1, 4'b0001, 0);
    cyc("rb_idle", 0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 8'h41, 0, 4'b0000, 0);
    cyc("rb_probe", 0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 8'h41, 0, 4'b0000, 2);
    cyc("rb_pkt1", 0, 4'b0100, 4'b0100, 4'b0000, 1, 1, 8'h41, 1, 4'b0100, 2);
    cyc("rb_pkt2", 1, 4'b0100, 4'b0000, 4'b0000, 1, 1, 8'h42, 1, 4'b0100, 2);
    cyc("rb_after", 0, 4'b0101, 4'b0101, 4'b0101, 1, 1, 8'h43, 0, 4'b0000, 0);
    cyc("rb_probe0", 0, 4'b0101, 4'b0101, 4'b0101, 1, 1, 8'h43, 0, 4'b0000, 0);
    cyc("rb_grant0", 0, 4'b0101, 4'b0101, 4'b0101, 1, 1, 8'h43, 1, 4'b0001, 0);
    cyc("rb_end", 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 8'h00, 0, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
